// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through in one cycle and runs
// word loads/stores over a req/ack port. Optional macro: MEM_ACCESS_MISALIGN_CHECK_EN.
module mem_access #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instruction,
    input  logic [DW-1:0] aluout,
    input  logic [AW-1:0] addr,
    input  logic          branch,
    input  logic          is_load,
    input  logic          is_store,
    input  logic [DW-1:0] store_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instruction,
    output logic [DW-1:0] out_result,
    output logic          out_branch,
    output logic [AW-1:0] out_target,
    output logic          out_misalign
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state_reg, state_next;
    logic          mem_req_reg, mem_req_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic          out_valid_reg, out_valid_next;
    logic [31:0]   out_instruction_reg, out_instruction_next;
    logic [DW-1:0] out_result_reg, out_result_next;
    logic          out_branch_reg, out_branch_next;
    logic [AW-1:0] out_target_reg, out_target_next;
    logic          out_misalign_reg, out_misalign_next;
    // Context of the outstanding access, needed when the ack comes back.
    logic [31:0]   pend_instr_reg, pend_instr_next;
    logic [AW-1:0] pend_addr_reg, pend_addr_next;
    logic          pend_load_reg, pend_load_next;
    logic          drop_reg, drop_next;

    logic          misaligned;
    logic [AW-1:0] req_addr;
    logic          mem_op;
    logic          accept;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    assign misaligned = (addr[1:0] != 2'b00);
    assign req_addr   = addr;
`else
    assign misaligned = 1'b0;
    assign req_addr   = {addr[AW-1:2], 2'b00};
`endif

    // A taken branch never touches memory, even if it is flagged load/store.
    assign mem_op   = (is_load | is_store) & ~branch;
    assign in_ready = (state_reg == IDLE) & (~out_valid_reg | out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        state_next           = state_reg;
        mem_req_next         = mem_req_reg;
        mem_we_next          = mem_we_reg;
        mem_addr_next        = mem_addr_reg;
        mem_wdata_next       = mem_wdata_reg;
        out_valid_next       = out_valid_reg;
        out_instruction_next = out_instruction_reg;
        out_result_next      = out_result_reg;
        out_branch_next      = out_branch_reg;
        out_target_next      = out_target_reg;
        out_misalign_next    = out_misalign_reg;
        pend_instr_next      = pend_instr_reg;
        pend_addr_next       = pend_addr_reg;
        pend_load_next       = pend_load_reg;
        drop_next            = drop_reg;

        if (flush || (out_valid_reg && out_ready))
            out_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (mem_op && !misaligned) begin
                        state_next      = ACCESS;
                        mem_req_next    = 1'b1;
                        mem_we_next     = is_store;
                        mem_addr_next   = req_addr;
                        mem_wdata_next  = store_data;
                        pend_instr_next = instruction;
                        pend_addr_next  = addr;
                        pend_load_next  = is_load;
                        drop_next       = 1'b0;
                    end else begin
                        out_valid_next       = 1'b1;
                        out_result_next      = (mem_op && misaligned) ? DW'(addr) : aluout;
                        out_branch_next      = branch;
                        out_target_next      = addr;
                        out_instruction_next = instruction;
                        out_misalign_next    = mem_op & misaligned;
                    end
                end
            end
            ACCESS: begin
                // A flush cannot abort the bus cycle; it only marks the result as dead.
                if (flush)
                    drop_next = 1'b1;
                if (mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    mem_we_next  = 1'b0;
                    if (!drop_reg && !flush) begin
                        out_valid_next       = 1'b1;
                        out_result_next      = pend_load_reg ? mem_rdata : DW'(pend_addr_reg);
                        out_branch_next      = 1'b0;
                        out_instruction_next = pend_instr_reg;
                        out_misalign_next    = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= IDLE;
            mem_req_reg         <= 1'b0;
            mem_we_reg          <= 1'b0;
            mem_addr_reg        <= '0;
            mem_wdata_reg       <= '0;
            out_valid_reg       <= 1'b0;
            out_instruction_reg <= '0;
            out_result_reg      <= '0;
            out_branch_reg      <= 1'b0;
            out_target_reg      <= '0;
            out_misalign_reg    <= 1'b0;
            pend_instr_reg      <= '0;
            pend_addr_reg       <= '0;
            pend_load_reg       <= 1'b0;
            drop_reg            <= 1'b0;
        end else begin
            state_reg           <= state_next;
            mem_req_reg         <= mem_req_next;
            mem_we_reg          <= mem_we_next;
            mem_addr_reg        <= mem_addr_next;
            mem_wdata_reg       <= mem_wdata_next;
            out_valid_reg       <= out_valid_next;
            out_instruction_reg <= out_instruction_next;
            out_result_reg      <= out_result_next;
            out_branch_reg      <= out_branch_next;
            out_target_reg      <= out_target_next;
            out_misalign_reg    <= out_misalign_next;
            pend_instr_reg      <= pend_instr_next;
            pend_addr_reg       <= pend_addr_next;
            pend_load_reg       <= pend_load_next;
            drop_reg            <= drop_next;
        end
    end

    assign mem_req         = mem_req_reg;
    assign mem_we          = mem_we_reg;
    assign mem_addr        = mem_addr_reg;
    assign mem_wdata       = mem_wdata_reg;
    assign out_valid       = out_valid_reg;
    assign out_instruction = out_instruction_reg;
    assign out_result      = out_result_reg;
    assign out_branch      = out_branch_reg;
    assign out_target      = out_target_reg;
    assign out_misalign    = out_misalign_reg;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus a randomized run
// scored against a transaction-level model with its own copy of memory.
module tb_mem_access;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   instruction = '0;
    logic [DW-1:0] aluout = '0;
    logic [AW-1:0] addr = '0;
    logic          branch = 1'b0;
    logic          is_load = 1'b0;
    logic          is_store = 1'b0;
    logic [DW-1:0] store_data = '0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instruction;
    logic [DW-1:0] out_result;
    logic          out_branch;
    logic [AW-1:0] out_target;
    logic          out_misalign;

    int errors = 0;
    int checks = 0;

    // Memory device model: acks after mem_wait idle cycles of mem_req.
    logic [31:0] dev_mem [256];
    logic [31:0] ref_mem [256];
    bit auto_mem  = 1'b1;
    bit rand_wait = 1'b0;
    int mem_wait  = 0;
    int wait_cnt  = 0;

    typedef struct {
        logic [31:0] result;
        logic        branch;
        logic [31:0] target;
        logic [31:0] instr;
        bit          is_mem;
    } exp_t;
    exp_t expq[$];

    mem_access #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .aluout(aluout), .addr(addr),
        .branch(branch), .is_load(is_load), .is_store(is_store),
        .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_result(out_result),
        .out_branch(out_branch), .out_target(out_target),
        .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (auto_mem && mem_req === 1'b1) begin
                if (wait_cnt >= mem_wait) begin
                    mem_ack   = 1'b1;
                    mem_rdata = dev_mem[mem_addr[9:2]];
                    if (mem_we)
                        dev_mem[mem_addr[9:2]] = mem_wdata;
                    wait_cnt = 0;
                    if (rand_wait)
                        mem_wait = $urandom_range(0, 2);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic clear_inputs();
        in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; branch = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, out_valid, out_branch, out_misalign} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {mem_req, mem_we, out_valid, out_branch, out_misalign});
        end
        checks++;
        if ({mem_addr, mem_wdata, out_result, out_target, out_instruction} !== 160'b0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h res=%h tgt=%h ins=%h required all 0",
                     mem_addr, mem_wdata, out_result, out_target, out_instruction);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        $display("reset: checked idle outputs");
        rst_n = 1'b1;
    endtask

    task automatic test_alu_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; aluout = vals[i]; instruction = 32'h1000 + i;
            addr = 32'h4 * i; branch = 1'b0; is_load = 1'b0; is_store = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== vals[i] || mem_req !== 1'b0 ||
                out_instruction !== 32'h1000 + i) begin
                errors++;
                $display("FAIL alu_pass_%0d: got v=%b res=%h req=%b ins=%h required v=1 res=%h req=0 ins=%h",
                         i, out_valid, out_result, mem_req, out_instruction, vals[i], 32'h1000 + i);
            end
            $display("alu txn %0d: result=%h", i, out_result);
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_load_wait();
        mem_wait = 2; dev_mem[8'h40] = 32'hDEADBEEF; out_ready = 1'b1;
        in_valid = 1'b1; is_load = 1'b1; addr = 32'h100; instruction = 32'hA5; aluout = 32'h7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 ||
                in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_access_%0d: got req=%b addr=%h we=%b rdy=%b v=%b required 1 100 0 0 0",
                         c, mem_req, mem_addr, mem_we, in_ready, out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'hDEADBEEF ||
            out_instruction !== 32'hA5 || out_branch !== 1'b0) begin
            errors++;
            $display("FAIL load_result: got req=%b v=%b res=%h ins=%h br=%b required 0 1 deadbeef a5 0",
                     mem_req, out_valid, out_result, out_instruction, out_branch);
        end
        $display("load txn: addr=100 result=%h", out_result);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_store_zero_wait();
        mem_wait = 0; out_ready = 1'b1;
        in_valid = 1'b1; is_store = 1'b1; addr = 32'h40; store_data = 32'hCAFE; instruction = 32'hB6;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE || mem_addr !== 32'h40) begin
            errors++;
            $display("FAIL store_req: got req=%b we=%b wdata=%h addr=%h required 1 1 cafe 40",
                     mem_req, mem_we, mem_wdata, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h40 || out_instruction !== 32'hB6) begin
            errors++;
            $display("FAIL store_result: got req=%b v=%b res=%h ins=%h required 0 1 40 b6",
                     mem_req, out_valid, out_result, out_instruction);
        end
        checks++;
        if (dev_mem[8'h10] !== 32'hCAFE) begin
            errors++;
            $display("FAIL store_written: got mem=%h required cafe", dev_mem[8'h10]);
        end
        $display("store txn: addr=40 result=%h", out_result);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_branch_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; branch = 1'b1; is_load = 1'b1; addr = 32'h200; aluout = 32'h55; instruction = 32'hC7;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            aluout = 32'h66; instruction = 32'hEE;
            checks++;
            if (out_valid !== 1'b1 || out_branch !== 1'b1 || out_target !== 32'h200 ||
                out_result !== 32'h55 || mem_req !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL branch_hold_%0d: got v=%b br=%b tgt=%h res=%h req=%b rdy=%b required 1 1 200 55 0 0",
                         c, out_valid, out_branch, out_target, out_result, mem_req, in_ready);
            end
        end
        clear_inputs();
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL branch_release: got in_ready=%b required 1", in_ready);
        end
        $display("branch txn: target=%h", out_target);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_flush_load();
        mem_wait = 2; out_ready = 1'b1;
        in_valid = 1'b1; is_load = 1'b1; addr = 32'h80; instruction = 32'hF1;
        @(negedge clk);
        clear_inputs();
        flush = 1'b1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_req_start: got req=%b required 1", mem_req);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            flush = 1'b0;
            checks++;
            if (mem_req !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_hold_%0d: got req=%b v=%b rdy=%b required 1 0 0", c, mem_req, out_valid, in_ready);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after_ack: got req=%b v=%b rdy=%b required 0 0 1", mem_req, out_valid, in_ready);
        end
        $display("flush txn: load to 80 discarded");
    endtask

    task automatic test_misalign();
        mem_wait = 0; out_ready = 1'b1; dev_mem[8'h40] = 32'hDEADBEEF;
        in_valid = 1'b1; is_load = 1'b1; addr = 32'h102; instruction = 32'hD8;
        @(negedge clk);
        clear_inputs();
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_misalign !== 1'b1 || out_result !== 32'h102) begin
            errors++;
            $display("FAIL misalign_flag: got req=%b v=%b mis=%b res=%h required 0 1 1 102",
                     mem_req, out_valid, out_misalign, out_result);
        end
`else
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || out_misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_align: got req=%b addr=%h mis=%b required 1 100 0", mem_req, mem_addr, out_misalign);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'hDEADBEEF || out_misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_load: got v=%b res=%h mis=%b required 1 deadbeef 0", out_valid, out_result, out_misalign);
        end
`endif
        $display("misalign txn: addr=102 result=%h misalign=%b", out_result, out_misalign);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_drain: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_access();
        auto_mem = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; is_load = 1'b1; addr = 32'h20; instruction = 32'h99;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_req: got req=%b required 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: got req=%b rdy=%b v=%b required 0 1 0", mem_req, in_ready, out_valid);
        end
        $display("reset txn: access abandoned");
        @(negedge clk);
        rst_n = 1'b1; auto_mem = 1'b1;
    endtask

    task automatic test_random(input int ncyc);
        exp_t e;
        int txn;
        int kind;
        logic [31:0] v;
        bit memop;
        txn = 0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom; dev_mem[i] = v; ref_mem[i] = v;
        end
        rand_wait = 1'b1; mem_wait = 1;
        for (int cyc = 0; cyc < ncyc + 60; cyc++) begin
            @(negedge clk);
            if (cyc < ncyc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                kind = $urandom_range(0, 2);
                is_load = (kind == 1); is_store = (kind == 2);
                branch = ($urandom_range(0, 3) == 0);
                addr = 32'($urandom_range(0, 255)) << 2;
                aluout = $urandom; store_data = $urandom; instruction = $urandom;
                out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                clear_inputs();
                out_ready = 1'b1;
                if (expq.size() == 0) break;
            end
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got result=%h with no transaction pending", out_result);
                end else begin
                    e = expq.pop_front();
                    if (out_result !== e.result || out_branch !== e.branch || out_instruction !== e.instr ||
                        out_misalign !== 1'b0 || (!e.is_mem && out_target !== e.target)) begin
                        errors++;
                        $display("FAIL rand_txn_%0d: got res=%h br=%b ins=%h tgt=%h mis=%b required res=%h br=%b ins=%h tgt=%h mis=0",
                                 txn, out_result, out_branch, out_instruction, out_target, out_misalign,
                                 e.result, e.branch, e.instr, e.target);
                    end
                    $display("rand txn %0d: result=%h branch=%b instr=%h", txn, out_result, out_branch, out_instruction);
                    txn++;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                memop = (is_load || is_store) && !branch;
                e.is_mem = memop;
                e.instr  = instruction;
                e.target = addr;
                e.branch = memop ? 1'b0 : branch;
                if (memop && is_store) begin
                    ref_mem[addr[9:2]] = store_data;
                    e.result = addr;
                end else if (memop) begin
                    e.result = ref_mem[addr[9:2]];
                end else begin
                    e.result = aluout;
                end
                expq.push_back(e);
            end
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: got %0d results outstanding required 0", expq.size());
        end
        rand_wait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_load_wait();
        test_store_zero_wait();
        test_branch_backpressure();
        test_flush_load();
        test_misalign();
        test_reset_mid_access();
        test_random(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
